// File: rtl/data_mem_mp_pkg.sv
// Shared constants and types for the multi-port PE data memory.
// Top-level parameter defaults and the write-source select live here.
package data_mem_mp_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 8;
  localparam int INST_W   = 32;
  localparam int WB_DELAY = 4;
  localparam int TX_BASE  = 128;
  localparam int RD_LAT   = 2;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_WB,
    SRC_TX
  } wr_src_e;

endpackage

// File: rtl/data_mem_mp_wr_arb.sv
// dm_wr_arb: shared write-port arbiter for load, write-back and TX.
// Owns the TX skid entry, the wrapping TX pointer and the sticky error.
module dm_wr_arb
  import data_mem_mp_pkg::*;
#(
  parameter int DATA_W  = data_mem_mp_pkg::DATA_W,
  parameter int ADDR_W  = data_mem_mp_pkg::ADDR_W,
  parameter int TX_BASE = data_mem_mp_pkg::TX_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wea,
  input  logic [ADDR_W-1:0] waddra,
  input  logic [DATA_W-1:0] dina,
  input  logic              wb_v,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              web,
  input  logic [DATA_W-1:0] dinb,
  output logic              tx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wb_err
);

  localparam logic [ADDR_W-1:0] TXB = ADDR_W'(TX_BASE);

  logic              skid_v;
  logic [DATA_W-1:0] skid_d;
  logic [ADDR_W-1:0] waddrb;
  logic              tx_acc;
  logic              tx_req;
  wr_src_e           sel;

  assign tx_ready = ~skid_v;
  assign tx_acc   = web & ~skid_v;
  assign tx_req   = skid_v | tx_acc;

  always_comb begin
    sel = SRC_NONE;
    if (wea)         sel = SRC_LOAD;
    else if (wb_v)   sel = SRC_WB;
    else if (tx_req) sel = SRC_TX;
  end

  // Writes are gated by rst_n so nothing lands while reset is held.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (sel)
      SRC_LOAD: begin
        wr_en   = rst_n;
        wr_addr = waddra;
        wr_data = dina;
      end
      SRC_WB: begin
        wr_en   = rst_n;
        wr_addr = wb_addr;
        wr_data = dina;
      end
      SRC_TX: begin
        wr_en   = rst_n;
        wr_addr = waddrb;
        wr_data = skid_v ? skid_d : dinb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v <= 1'b0;
      skid_d <= '0;
      waddrb <= TXB;
      wb_err <= 1'b0;
    end else begin
      if (sel == SRC_TX) begin
        skid_v <= 1'b0;
        waddrb <= (waddrb == '1) ? TXB : waddrb + 1'b1;
      end else if (tx_acc) begin
        skid_v <= 1'b1;
        skid_d <= dinb;
      end
      if (wea && wb_v) wb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/sdp_bram.sv
// Simple dual-port block RAM: one write port, one read port.
// Two-cycle read: array register then output register (regceb).
module sdp_bram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              enb,
  input  logic              regceb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] q1;

  always_ff @(posedge clk) begin
    if (wea) mem[addra] <= dina;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1    <= '0;
      doutb <= '0;
    end else begin
      if (enb)    q1    <= mem[addrb];
      if (regceb) doutb <= q1;
    end
  end

endmodule

// File: rtl/data_mem_mp.sv
// Multi-port PE data memory: one arbitrated write path, two
// registered read ports on mirrored BRAMs with write-first bypass.
module data_mem_mp
  import data_mem_mp_pkg::*;
#(
  parameter int DATA_W   = data_mem_mp_pkg::DATA_W,
  parameter int ADDR_W   = data_mem_mp_pkg::ADDR_W,
  parameter int INST_W   = data_mem_mp_pkg::INST_W,
  parameter int WB_DELAY = data_mem_mp_pkg::WB_DELAY,
  parameter int TX_BASE  = data_mem_mp_pkg::TX_BASE,
  parameter int RD_LAT   = data_mem_mp_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wea,
  input  logic [DATA_W-1:0] dina,
  input  logic              wben,
  input  logic              web,
  input  logic [DATA_W-1:0] dinb,
  output logic              tx_ready,
  input  logic              inst_v,
  input  logic [INST_W-1:0] inst,
  input  logic              shift_v,
  input  logic              rden,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb,
  output logic              rvalid,
  output logic              wb_err
);

  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [ADDR_W-1:0] waddra;
  logic [ADDR_W-1:0] raddra;
  logic [ADDR_W-1:0] raddrb;
  logic [ADDR_W-1:0] dl [WB_DELAY];
  logic              wb_v;
  logic [ADDR_W-1:0] wb_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] bram_a;
  logic [DATA_W-1:0] bram_b;
  logic [RD_LAT-1:0] vpipe;
  logic              hit_a1, hit_a2;
  logic              hit_b1, hit_b2;
  logic [DATA_W-1:0] byp_a1, byp_a2;
  logic [DATA_W-1:0] byp_b1, byp_b2;

  assign dst  = inst[ADDR_W-1:0];
  assign src1 = inst[2*ADDR_W-1:ADDR_W];
  assign src2 = inst[3*ADDR_W-1:2*ADDR_W];

  if (INST_W > 3*ADDR_W) begin : g_spare
    logic unused_inst;
    assign unused_inst = ^inst[INST_W-1:3*ADDR_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddra  <= '0;
      raddra  <= '0;
      raddrb  <= '0;
      wb_v    <= 1'b0;
      wb_addr <= '0;
      for (int i = 0; i < WB_DELAY; i++) dl[i] <= '0;
    end else begin
      if (wea)          waddra <= waddra + 1'b1;
      else if (shift_v) raddra <= raddra + 1'b1;
      if (inst_v) begin
        raddra <= src1;
        raddrb <= src2;
      end
      dl[0] <= inst_v ? dst : '0;
      for (int i = 1; i < WB_DELAY; i++) dl[i] <= dl[i-1];
      // Commit address is the dst issued WB_DELAY cycles before wben.
      wb_v    <= wben;
      wb_addr <= dl[WB_DELAY-1];
    end
  end

  dm_wr_arb #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TX_BASE (TX_BASE)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wea      (wea),
    .waddra   (waddra),
    .dina     (dina),
    .wb_v     (wb_v),
    .wb_addr  (wb_addr),
    .web      (web),
    .dinb     (dinb),
    .tx_ready (tx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wb_err   (wb_err)
  );

  sdp_bram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bram_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .wea    (wr_en),
    .addra  (wr_addr),
    .dina   (wr_data),
    .enb    (rden),
    .regceb (1'b1),
    .addrb  (raddra),
    .doutb  (bram_a)
  );

  sdp_bram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bram_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .wea    (wr_en),
    .addra  (wr_addr),
    .dina   (wr_data),
    .enb    (rden),
    .regceb (1'b1),
    .addrb  (raddrb),
    .doutb  (bram_b)
  );

  // Bypass stages track the BRAM array and output registers exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe  <= '0;
      hit_a1 <= 1'b0;
      hit_b1 <= 1'b0;
      hit_a2 <= 1'b0;
      hit_b2 <= 1'b0;
      byp_a1 <= '0;
      byp_b1 <= '0;
      byp_a2 <= '0;
      byp_b2 <= '0;
    end else begin
      vpipe <= RD_LAT'({vpipe, rden});
      if (rden) begin
        hit_a1 <= wr_en && (wr_addr == raddra);
        hit_b1 <= wr_en && (wr_addr == raddrb);
        byp_a1 <= wr_data;
        byp_b1 <= wr_data;
      end
      hit_a2 <= hit_a1;
      hit_b2 <= hit_b1;
      byp_a2 <= byp_a1;
      byp_b2 <= byp_b1;
    end
  end

  assign douta  = hit_a2 ? byp_a2 : bram_a;
  assign doutb  = hit_b2 ? byp_b2 : bram_b;
  assign rvalid = vpipe[RD_LAT-1];

endmodule

// File: tb/tb_data_mem_mp.sv
// Directed bench for data_mem_mp: load/read, write-back, TX skid,
// TX wrap, bypass/shift and asynchronous reset.
module tb_data_mem_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wea;
  logic [31:0] dina;
  logic        wben;
  logic        web;
  logic [31:0] dinb;
  logic        tx_ready;
  logic        inst_v;
  logic [31:0] inst;
  logic        shift_v;
  logic        rden;
  logic [31:0] douta;
  logic [31:0] doutb;
  logic        rvalid;
  logic        wb_err;

  int tests_run = 0;
  int fails = 0;

  data_mem_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wea      (wea),
    .dina     (dina),
    .wben     (wben),
    .web      (web),
    .dinb     (dinb),
    .tx_ready (tx_ready),
    .inst_v   (inst_v),
    .inst     (inst),
    .shift_v  (shift_v),
    .rden     (rden),
    .douta    (douta),
    .doutb    (doutb),
    .rvalid   (rvalid),
    .wb_err   (wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wea = 0; dina = 0; wben = 0; web = 0; dinb = 0;
    inst_v = 0; inst = 0; shift_v = 0; rden = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic load(input logic [31:0] d);
    wea = 1; dina = d;
    tick();
    wea = 0; dina = 0;
  endtask

  task automatic set_ptr(input logic [7:0] s1, input logic [7:0] s2,
                         input logic [7:0] d);
    inst_v = 1; inst = {8'h00, s2, s1, d};
    tick();
    inst_v = 0; inst = 0;
  endtask

  task automatic rd(output logic [31:0] a, output logic [31:0] b,
                    output logic v0, output logic v1, output logic v2);
    rden = 1;
    tick();
    rden = 0;
    v0 = rvalid;
    tick();
    v1 = rvalid; a = douta; b = doutb;
    tick();
    v2 = rvalid;
  endtask

  task automatic read_at(input logic [7:0] s1, input logic [7:0] s2,
                         output logic [31:0] a, output logic [31:0] b);
    logic v0, v1, v2;
    set_ptr(s1, s2, 8'h00);
    rd(a, b, v0, v1, v2);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
    tests_run++; if (douta !== 32'h0) begin fails++; $display("FAIL rst_douta got=%h exp=0", douta); end
    tests_run++; if (doutb !== 32'h0) begin fails++; $display("FAIL rst_doutb got=%h exp=0", doutb); end
    tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
    tests_run++; if (wb_err !== 1'b0) begin fails++; $display("FAIL rst_wb_err got=%b exp=0", wb_err); end
  endtask

  task automatic test_load_read();
    logic [31:0] a, b;
    logic v0, v1, v2;
    for (int i = 0; i < 4; i++) load(32'hA0 + i);
    set_ptr(8'd2, 8'd3, 8'd0);
    rd(a, b, v0, v1, v2);
    tests_run++; if (a !== 32'hA2) begin fails++; $display("FAIL ld_douta got=%h exp=a2", a); end
    tests_run++; if (b !== 32'hA3) begin fails++; $display("FAIL ld_doutb got=%h exp=a3", b); end
    tests_run++; if (v0 !== 1'b0) begin fails++; $display("FAIL ld_rvalid_t1 got=%b exp=0", v0); end
    tests_run++; if (v1 !== 1'b1) begin fails++; $display("FAIL ld_rvalid_t2 got=%b exp=1", v1); end
    tests_run++; if (v2 !== 1'b0) begin fails++; $display("FAIL ld_rvalid_t3 got=%b exp=0", v2); end
  endtask

  task automatic test_writeback();
    logic [31:0] a, b;
    set_ptr(8'd0, 8'd0, 8'h10);
    repeat (3) tick();
    wben = 1;
    tick();
    wben = 0; dina = 32'h55;
    tick();
    dina = 0;
    tests_run++; if (wb_err !== 1'b0) begin fails++; $display("FAIL wb_err_clean got=%b exp=0", wb_err); end
    read_at(8'h10, 8'h10, a, b);
    tests_run++; if (a !== 32'h55) begin fails++; $display("FAIL wb_data_a got=%h exp=55", a); end
    tests_run++; if (b !== 32'h55) begin fails++; $display("FAIL wb_data_b got=%h exp=55", b); end
    set_ptr(8'd0, 8'd0, 8'h10);
    repeat (3) tick();
    wben = 1;
    tick();
    wben = 0; wea = 1; dina = 32'h66;
    tick();
    wea = 0; dina = 0;
    tests_run++; if (wb_err !== 1'b1) begin fails++; $display("FAIL wb_err_set got=%b exp=1", wb_err); end
    read_at(8'h10, 8'd4, a, b);
    tests_run++; if (a !== 32'h55) begin fails++; $display("FAIL wb_dropped got=%h exp=55", a); end
    tests_run++; if (b !== 32'h66) begin fails++; $display("FAIL wb_load_won got=%h exp=66", b); end
    tests_run++; if (wb_err !== 1'b1) begin fails++; $display("FAIL wb_err_sticky got=%b exp=1", wb_err); end
  endtask

  task automatic test_tx_skid();
    logic [31:0] a, b;
    wea = 1; dina = 32'h99; web = 1; dinb = 32'h77;
    tick();
    web = 0; dinb = 0; dina = 32'h9A;
    tests_run++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL skid_busy1 got=%b exp=0", tx_ready); end
    tick();
    wea = 0; dina = 0;
    tests_run++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL skid_busy2 got=%b exp=0", tx_ready); end
    tick();
    tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL skid_drained got=%b exp=1", tx_ready); end
    read_at(8'd128, 8'd5, a, b);
    tests_run++; if (a !== 32'h77) begin fails++; $display("FAIL skid_data got=%h exp=77", a); end
    tests_run++; if (b !== 32'h99) begin fails++; $display("FAIL skid_load5 got=%h exp=99", b); end
    read_at(8'd6, 8'd6, a, b);
    tests_run++; if (a !== 32'h9A) begin fails++; $display("FAIL skid_load6 got=%h exp=9a", a); end
  endtask

  task automatic test_tx_wrap();
    logic [31:0] a, b;
    do_reset();
    for (int i = 0; i < 127; i++) load(32'h1000 + i);
    load(32'hDEAD);
    web = 1;
    for (int i = 0; i < 129; i++) begin
      dinb = 32'h2000 + i;
      tick();
    end
    web = 0; dinb = 0;
    tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL wrap_ready got=%b exp=1", tx_ready); end
    read_at(8'd127, 8'd128, a, b);
    tests_run++; if (a !== 32'hDEAD) begin fails++; $display("FAIL wrap_127 got=%h exp=dead", a); end
    tests_run++; if (b !== 32'h2080) begin fails++; $display("FAIL wrap_128 got=%h exp=2080", b); end
    read_at(8'd129, 8'd255, a, b);
    tests_run++; if (a !== 32'h2001) begin fails++; $display("FAIL wrap_129 got=%h exp=2001", a); end
    tests_run++; if (b !== 32'h207F) begin fails++; $display("FAIL wrap_255 got=%h exp=207f", b); end
    read_at(8'd0, 8'd126, a, b);
    tests_run++; if (a !== 32'h1000) begin fails++; $display("FAIL wrap_0 got=%h exp=1000", a); end
    tests_run++; if (b !== 32'h107E) begin fails++; $display("FAIL wrap_126 got=%h exp=107e", b); end
  endtask

  task automatic test_bypass_shift();
    logic [31:0] a, b;
    logic v0, v1, v2;
    do_reset();
    for (int i = 0; i < 9; i++)
      load(i == 5 ? 32'h11 : (i == 8 ? 32'h88 : 32'h30 + i));
    set_ptr(8'd5, 8'd6, 8'd5);
    repeat (3) tick();
    wben = 1;
    tick();
    wben = 0; dina = 32'h22; rden = 1;
    tick();
    dina = 0; rden = 0;
    tick();
    tests_run++; if (douta !== 32'h22) begin fails++; $display("FAIL byp_douta got=%h exp=22", douta); end
    tests_run++; if (doutb !== 32'h36) begin fails++; $display("FAIL byp_doutb got=%h exp=36", doutb); end
    tests_run++; if (rvalid !== 1'b1) begin fails++; $display("FAIL byp_rvalid got=%b exp=1", rvalid); end
    tick();
    tests_run++; if (rvalid !== 1'b0) begin fails++; $display("FAIL hold_rvalid got=%b exp=0", rvalid); end
    tests_run++; if (douta !== 32'h22) begin fails++; $display("FAIL hold_douta got=%h exp=22", douta); end
    shift_v = 1;
    repeat (3) tick();
    shift_v = 0;
    rd(a, b, v0, v1, v2);
    tests_run++; if (a !== 32'h88) begin fails++; $display("FAIL shift_ptr got=%h exp=88", a); end
    shift_v = 1; inst_v = 1; inst = {8'h00, 8'd2, 8'd1, 8'd0};
    tick();
    shift_v = 0; inst_v = 0; inst = 0;
    rd(a, b, v0, v1, v2);
    tests_run++; if (a !== 32'h31) begin fails++; $display("FAIL inst_wins_a got=%h exp=31", a); end
    tests_run++; if (b !== 32'h32) begin fails++; $display("FAIL inst_wins_b got=%h exp=32", b); end
    read_at(8'd5, 8'd5, a, b);
    tests_run++; if (a !== 32'h22) begin fails++; $display("FAIL byp_mem got=%h exp=22", a); end
  endtask

  task automatic test_async_reset();
    logic [31:0] a, b;
    wea = 1; dina = 32'hBAD; web = 1; dinb = 32'h5A; rden = 1;
    tick();
    web = 0; dinb = 0;
    tests_run++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL ar_skid_pend got=%b exp=0", tx_ready); end
    tick();
    tests_run++; if (rvalid !== 1'b1) begin fails++; $display("FAIL ar_pre_rvalid got=%b exp=1", rvalid); end
    web = 1; dinb = 32'h5B;
    #3;
    rst_n = 0;
    #1;
    tests_run++; if (rvalid !== 1'b0) begin fails++; $display("FAIL ar_rvalid got=%b exp=0", rvalid); end
    tests_run++; if (douta !== 32'h0) begin fails++; $display("FAIL ar_douta got=%h exp=0", douta); end
    tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL ar_tx_ready got=%b exp=1", tx_ready); end
    tick();
    tick();
    idle_in();
    rst_n = 1;
    tick();
    tests_run++; if (rvalid !== 1'b0) begin fails++; $display("FAIL ar_flight got=%b exp=0", rvalid); end
    web = 1; dinb = 32'hCC;
    tick();
    web = 0; dinb = 0;
    read_at(8'd128, 8'd0, a, b);
    tests_run++; if (a !== 32'hCC) begin fails++; $display("FAIL ar_waddrb got=%h exp=cc", a); end
    tests_run++; if (b !== 32'h30) begin fails++; $display("FAIL ar_no_write got=%h exp=30", b); end
    read_at(8'd129, 8'd129, a, b);
    tests_run++; if (a !== 32'h2001) begin fails++; $display("FAIL ar_skid_lost got=%h exp=2001", a); end
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    test_reset();
    test_load_read();
    test_writeback();
    test_tx_skid();
    test_tx_wrap();
    test_bypass_shift();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_mp.md
Name: data_mem_mp

Overview:
- Parametrised successor to the PE data memory.
- One shared write path, arbitrated between three sources: stream load (port A), ALU write-back (delayed destination) and TX transfer (port B, into an upper region).
- Two independent registered read ports (src1, src2), each backed by its own sdp_bram copy so that both copies always hold identical contents.
- New versus the previous generation: TX skid buffer with a ready handshake, read valids, write-to-read bypass, a bounded wrapping TX region, and a sticky write-back collision flag.

Parameters:
- DATA_W, 32: word width. Equals 2x `DATA_WIDTH`.
- ADDR_W, 8: address width. Depth = 2**ADDR_W.
- INST_W, 32: instruction width. Must be >= 3*ADDR_W.
- WB_DELAY, 4: cycles from inst_v to write-back address use. Must be >= 1.
- TX_BASE, 128: first address of the TX region. TX region = [TX_BASE, 2**ADDR_W-1].
- RD_LAT, 2: BRAM read latency (HIGH_PERFORMANCE). Fixed at 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wea  in  1  load write strobe.
- dina  in  DATA_W  load / write-back data.
- wben  in  1  write-back request. Commit happens one cycle later using the delayed destination.
- web  in  1  TX write request.
- dinb  in  DATA_W  TX data.
- tx_ready  out  1  TX may be accepted this cycle.
- inst_v  in  1  instruction valid.
- inst  in  INST_W  fields: [ADDR_W-1:0] dst, [2*ADDR_W-1:ADDR_W] src1, [3*ADDR_W-1:2*ADDR_W] src2.
- shift_v  in  1  increment src1 read pointer.
- rden  in  1  issue read on both ports.
- douta  out  DATA_W  src1 read data.
- doutb  out  DATA_W  src2 read data.
- rvalid  out  1  douta/doutb valid.
- wb_err  out  1  sticky: a write-back was dropped.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - waddra=0, waddrb=TX_BASE, raddra=raddrb=0.
  - Write-back delay line = 0; TX skid buffer empty.
  - tx_ready=1, rvalid=0, douta=doutb=0, wb_err=0.
  - Memory contents are not cleared.
- Pointer updates (priority, one per cycle):
  - wea: waddra+1, wrapping at 2**ADDR_W.
  - else shift_v: raddra+1, wrapping.
  - inst_v is applied after the above and overrides raddra/raddrb: src1->raddra, src2->raddrb, dst enters the write-back delay line.
  - When inst_v and shift_v occur together, inst_v wins for raddra.
- Write-back:
  - wben at cycle t commits at t+1 to the address dst captured at the inst_v WB_DELAY cycles before t, with dina sampled at t+1.
- Write arbitration, per cycle (single write into both copies):
  1. Load (wea): writes dina at waddra.
  2. Write-back commit.
  3. TX: the skid entry if present, else the live web.
- TX handshake:
  - web is accepted only when tx_ready=1.
  - If an accepted TX loses arbitration, it is held in a 1-entry skid buffer and tx_ready=0 next cycle.
  - The skid buffer drains on the first cycle with no higher-priority write; tx_ready returns to 1 the cycle after the drain.
  - After each TX write, waddrb advances: 2**ADDR_W-1 -> TX_BASE (no spill below TX_BASE).
- Collision: load and write-back commit in the same cycle -> write-back is dropped, wb_err set. wb_err is cleared only by reset.
- Read:
  - rden at cycle t -> douta/doutb valid at t+RD_LAT with rvalid=1 for one cycle per rden. Back-to-back rden is fully pipelined.
  - Write-first bypass: if the cycle-t write address equals raddra (or raddrb), that port returns the cycle-t write data, forwarded through the same latency.
  - When rden=0, outputs hold their last value and rvalid=0.
- Reset mid-operation: any pending skid entry, write-back and read in flight are discarded; nothing is written after rst_n falls.

Decomposition:
- Shared package / `parameters.vh`: DATA_W, ADDR_W, INST_W, field-offset constants (DST_LSB=0, SRC1_LSB=ADDR_W, SRC2_LSB=2*ADDR_W), TX_BASE default.
- Sub-modules:
  - The existing sdp_bram is instantiated twice, regceb tied high.
  - One new sub-module, dm_wr_arb: priority mux, TX skid buffer, tx_ready, waddrb wrap, wb_err. It outputs wr_en, wr_addr and wr_data to both BRAMs and the bypass compare.

Test Plan:
- Load then read: reset; wea x4 with data 0xA0..0xA3 -> addresses 0..3. Then inst_v with src1=2, src2=3 and rden at t -> at t+2 douta=0xA2, doutb=0xA3, rvalid=1 for exactly one cycle.
- Write-back timing: inst_v dst=0x10 at t0; wben at t0+4; dina=0x55 at t0+5 -> later read of 0x10 returns 0x55. With wea also asserted at t0+5 -> 0x10 unchanged, wb_err=1 and stays 1.
- TX skid: web with dinb=0x77 while wea is high -> tx_ready=0 next cycle. Entry drains when wea drops; read of 128 returns 0x77; tx_ready=1 afterwards.
- TX wrap: 129 TX writes from reset -> writes land at 128..255 then 128; address 127 is never written (verify by preloading 0xDEAD at 127).
- Bypass and shift: preload addr 5=0x11; write 0x22 to 5 in the same cycle as rden with raddra=5 -> douta=0x22. Then shift_v x3 from raddra=5 -> raddra=8. Simultaneous inst_v with src1=1 -> raddra=1.
- Async reset: drop rst_n mid-burst with a skid entry pending -> outputs clear immediately; no write occurs after the edge; tx_ready=1 and waddrb=128 after release.
